// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one memory request in flight,
// and buffers returned words with their PCs for decode. A redirect flushes everything.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_pc;
  logic          r_outstanding;
  logic          r_discard;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_buf_pc   [FIFO_DEPTH];
  logic [31:0]   r_buf_inst [FIFO_DEPTH];

  logic w_issue;
  logic w_grant;
  logic w_resp;
  logic w_push;
  logic w_pop;
  logic w_unused;

  // Issuing only when nothing is in flight reserves a buffer slot for the response,
  // so a push never has to be refused.
  assign w_issue  = rst_n && !r_outstanding && (r_count < DEPTH_C) && !redirect_i;
  assign w_grant  = w_issue && imem_gnt_i;
  assign w_resp   = imem_rvalid_i && r_outstanding;
  assign w_push   = w_resp && !r_discard && !redirect_i;
  assign w_pop    = (r_count != '0) && ready_i && !redirect_i;
  assign w_unused = ^target_i[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_outstanding <= 1'b0;
      r_discard     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= {target_i[31:2], 2'b00};
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      // A response still on its way belongs to the old stream and must be dropped.
      if (r_outstanding && !imem_rvalid_i) begin
        r_discard <= 1'b1;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end
    end else begin
      if (w_grant) begin
        r_outstanding <= 1'b1;
        r_req_pc      <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end
      if (w_resp) begin
        r_outstanding <= 1'b0;
        r_discard     <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (w_push && (r_wr_ptr == PW'(gi))) begin
          r_buf_pc[gi]   <= r_req_pc;
          r_buf_inst[gi] <= imem_rdata_i;
        end
      end
    end
  endgenerate

  assign imem_req_o  = w_issue;
  assign imem_addr_o = r_fetch_pc;
  assign valid_o     = (r_count != '0);
  assign inst_o      = valid_o ? r_buf_inst[r_rd_ptr] : NOP_INST;
  assign pc_o        = valid_o ? r_buf_pc[r_rd_ptr] : 32'h0000_0000;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of decode. Holds the architectural fetch PC and issues word fetches to instruction memory with at most one outstanding request. Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. On a jump or taken-branch redirect from decode it flushes all in-flight and buffered work and restarts fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2
- NOP_INST, 32'h0000_0013, value driven on inst_o while the buffer is empty

- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- imem_req_o  output  1  fetch request; held until granted
- imem_addr_o  output  32  fetch address, equal to fetch_pc; [1:0] always 0
- imem_gnt_i  input  1  request accepted this cycle; only meaningful with imem_req_o
- imem_rvalid_i  input  1  read data valid; earliest the cycle after the grant
- imem_rdata_i  input  32  instruction word
- redirect_i  input  1  jump or taken branch from decode, single-cycle pulse
- target_i  input  32  redirect target; [1:0] ignored, forced to 0
- ready_i  input  1  decode accepts the head instruction this cycle
- valid_o  output  1  buffer non-empty
- inst_o  output  32  head instruction, or NOP_INST when empty
- pc_o  output  32  PC of the head instruction, 0 when empty

## Operation
- State: fetch_pc, req_pc (address of the outstanding request), outstanding flag, discard flag, FIFO of {pc, inst} with count.
- Issue condition: !outstanding && (count + outstanding) < FIFO_DEPTH && !redirect_i. imem_req_o is combinational from this condition.
- Grant (imem_req_o && imem_gnt_i): outstanding <= 1, req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (32-bit wrap, 0xFFFF_FFFC -> 0).
- Response (imem_rvalid_i): outstanding <= 0. If discard = 1 or redirect_i = 1, drop the data and clear discard. Otherwise push {req_pc, imem_rdata_i}.
- Pop: valid_o && ready_i && !redirect_i removes the head entry.
- Push and pop in the same cycle leave count unchanged. Push is always legal because space is reserved at issue time; the invariant count + outstanding <= FIFO_DEPTH always holds.
- Redirect (highest priority):
  - fetch_pc <= {target_i[31:2], 2'b00}.
  - FIFO count <= 0; no pop that cycle.
  - If outstanding && !imem_rvalid_i, discard <= 1.
  - No request issues in the redirect cycle.
- imem_rvalid_i with no outstanding request is a protocol error. It is ignored: no push, no state change.

## Timing
- Reset values: fetch_pc = RESET_PC, outstanding = 0, discard = 0, count = 0. Outputs: imem_req_o = 0 while rst_n low, valid_o = 0, inst_o = NOP_INST, pc_o = 0, imem_addr_o = RESET_PC.
- First cycle after reset release: imem_req_o = 1 with imem_addr_o = RESET_PC.
- Latency: grant in cycle N, rvalid in cycle N+k (k >= 1), entry visible on valid_o/inst_o/pc_o in cycle N+k+1.
- Back-to-back issue: the next request may assert in cycle N+k+1, the cycle after the response.
- FIFO full (count = FIFO_DEPTH): imem_req_o = 0 until a pop frees an entry. The request reasserts the cycle after the pop.
- The FIFO head is registered. Popping an entry exposes the next entry or the empty values in the following cycle.
- A redirect in cycle R gives valid_o = 0 from R+1. The first request to the target issues in R+1 if nothing is outstanding. Otherwise it issues the cycle after the discarded response returns.
- An asynchronous reset mid-operation clears all state immediately. A response arriving after release with no outstanding request is ignored.

## Test plan
- Reset release, memory grants immediately with rvalid k=1 returning 0xA0+addr, ready_i=1 -> requests to 0x0, 0x4, 0x8 every 2 cycles; valid_o first high in cycle 3 with pc_o=0x0, inst_o=0xA0.
- ready_i=0, FIFO_DEPTH=2 -> exactly 2 grants (0x0, 0x4), then imem_req_o stays 0. Raising ready_i for one cycle pops pc 0x0, and the request to 0x8 asserts the next cycle.
- Redirect to 0x1003 with 2 buffered entries and nothing outstanding -> valid_o=0 next cycle; next imem_addr_o = 0x1000; old entries never appear.
- Redirect while a request to 0x8 is outstanding, rvalid 3 cycles later -> that response is dropped; the next grant is to the target; the first pc_o after redirect equals the target.
- Redirect coinciding with imem_rvalid_i, and separately with an attempted issue -> response dropped, discard stays 0, imem_req_o = 0 in that cycle.
- fetch_pc at 0xFFFF_FFFC -> the following request is to 0x0000_0000. Mid-stream rst_n pulse -> all outputs return to reset values asynchronously, and fetch restarts at RESET_PC.
